cnn_layer_sequencer: RTL and testbench

- Programmable layer scheduler in front of the CNN engine top.
- Holds a small descriptor table of layer types (conv, pool, fc, act) and runs the entries in order.
- For each layer: issues the engine's valid/enable, waits for that engine's completion strobe, then advances.
- Reports busy, done and timeout error to the host/testbench sequence layer.

---
 rtl/cnn_layer_sequencer.sv | 150 +++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_sequencer.sv
// Layer scheduler: walks a descriptor table of layer types, pulses each engine and
// waits on its completion under a watchdog. CNN_SEQ_PERF_EN adds a run-cycle counter.
module cnn_layer_sequencer #(
  parameter int MAX_LAYERS     = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_wr_en,
  input  logic [$clog2(MAX_LAYERS)-1:0]   cfg_wr_addr,
  input  logic [1:0]                      cfg_wr_type,
  input  logic [$clog2(MAX_LAYERS):0]     cfg_num_layers,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [$clog2(MAX_LAYERS)-1:0]   cur_layer,
  output logic                            conv_valid_in,
  input  logic                            conv_valid_out,
  output logic                            pool_valid_in,
  input  logic                            pool_valid_out,
  output logic                            fc_en,
  input  logic                            fc_valid,
  output logic                            act_valid_in,
  input  logic                            act_valid_out,
  output logic [31:0]                     perf_total_cycles
);
  localparam int AW = $clog2(MAX_LAYERS);
  localparam logic [AW:0]          MAX_CNT = (AW+1)'(MAX_LAYERS);
  localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT_CYCLES-1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_FIN, S_ERR} state_e;

  // Type encoding doubles as the bit position in {act, fc, pool, conv}.
  function automatic logic [3:0] onehot(input logic [1:0] t);
    return 4'b0001 << t;
  endfunction

  state_e               state_q;
  logic [1:0]           tbl_q [MAX_LAYERS];
  logic [AW:0]          cnt_q;
  logic [AW-1:0]        cur_q;
  logic [CNT_WIDTH-1:0] wd_q;
  logic                 busy_q, done_q, error_q;
  logic [3:0]           strb_q;

  logic [AW:0]   cnt_sat;
  logic [AW-1:0] nxt_idx;
  logic          last, cpl;

  assign cnt_sat = (cfg_num_layers > MAX_CNT) ? MAX_CNT : cfg_num_layers;
  assign nxt_idx = cur_q + AW'(1);
  assign last    = ({1'b0, cur_q} == cnt_q - (AW+1)'(1));
  assign cpl     = |(onehot(tbl_q[cur_q]) &
                     {act_valid_out, fc_valid, pool_valid_out, conv_valid_out});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < MAX_LAYERS; i++) tbl_q[i] <= 2'b00;
      cnt_q   <= '0;
      cur_q   <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      strb_q  <= '0;
    end else begin
      done_q    <= 1'b0;
      strb_q[3] <= 1'b0;
      strb_q[1] <= 1'b0;
      strb_q[0] <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_wr_en) tbl_q[cfg_wr_addr] <= cfg_wr_type;
          if (start) begin
            cnt_q   <= cnt_sat;
            cur_q   <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            if (cnt_sat == '0) state_q <= S_FIN;
            else begin
              state_q <= S_ISSUE;
              strb_q  <= onehot(tbl_q[0]);
            end
          end
        end
        S_ISSUE: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        // Completion is checked before the watchdog so it wins a tie.
        S_WAIT: begin
          if (cpl) begin
            strb_q[2] <= 1'b0;
            state_q   <= S_NEXT;
          end else if (wd_q == WD_LAST) begin
            strb_q[2] <= 1'b0;
            state_q   <= S_ERR;
          end else begin
            wd_q <= wd_q + CNT_WIDTH'(1);
          end
        end
        S_NEXT: begin
          if (last) state_q <= S_FIN;
          else begin
            cur_q   <= nxt_idx;
            strb_q  <= onehot(tbl_q[nxt_idx]);
            state_q <= S_ISSUE;
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ERR: begin
          error_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign cur_layer     = cur_q;
  assign conv_valid_in = strb_q[0];
  assign pool_valid_in = strb_q[1];
  assign fc_en         = strb_q[2];
  assign act_valid_in  = strb_q[3];

`ifdef CNN_SEQ_PERF_EN
  // Counts from the accepted start through the done cycle.
  logic [31:0] perf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   perf_q <= '0;
    else if (state_q == S_IDLE && start)          perf_q <= '0;
    else if ((busy_q || done_q) && perf_q != '1)  perf_q <= perf_q + 32'd1;
  end
  assign perf_total_cycles = perf_q;
`else
  assign perf_total_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: table of full runs plus hand sequences for reset,
// timeout and spurious-completion cases; engine strobes checked via a scoreboard queue.
module tb_cnn_layer_sequencer;
  logic        clk, rst_n, cfg_wr_en, start;
  logic [2:0]  cfg_wr_addr;
  logic [1:0]  cfg_wr_type;
  logic [3:0]  cfg_num_layers;
  logic        busy, done, error;
  logic [2:0]  cur_layer;
  logic        conv_valid_in, conv_valid_out, pool_valid_in, pool_valid_out;
  logic        fc_en, fc_valid, act_valid_in, act_valid_out;
  logic [31:0] perf_total_cycles;

`ifdef CNN_SEQ_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  cnn_layer_sequencer #(.MAX_LAYERS(8), .TIMEOUT_CYCLES(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_type(cfg_wr_type), .cfg_num_layers(cfg_num_layers), .start(start),
    .busy(busy), .done(done), .error(error), .cur_layer(cur_layer),
    .conv_valid_in(conv_valid_in), .conv_valid_out(conv_valid_out),
    .pool_valid_in(pool_valid_in), .pool_valid_out(pool_valid_out),
    .fc_en(fc_en), .fc_valid(fc_valid),
    .act_valid_in(act_valid_in), .act_valid_out(act_valid_out),
    .perf_total_cycles(perf_total_cycles));

  typedef struct { int ty; int cyc; int idx; } ev_t;
  typedef struct {
    logic [7:0][1:0] ty;
    int n, lat, exp_done, exp_fc, exp_strobes;
  } vec_t;

  ev_t        sbq[$];
  vec_t       vecs[6];
  int         cyc, n_checks, n_pass, t0, when;
  int         strobe_tot, busy_tot, fc_tot, done_tot;
  int         lat[4], cd[4];
  logic [3:0] resp, spur;
  logic       fc_prev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, want);
  endtask

  // One cycle: advance to the negedge, score strobes, then run the engine models.
  task automatic tick();
    logic [3:0] ev;
    ev_t e;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      foreach (cd[i]) cd[i] = 0;
      resp    = '0;
      fc_prev = 1'b0;
    end else begin
      ev = {act_valid_in, fc_en & ~fc_prev, pool_valid_in, conv_valid_in};
      for (int i = 0; i < 4; i++) begin
        if (ev[i]) begin
          strobe_tot++;
          if (sbq.size() == 0) chk("unexpected_strobe", i, -1);
          else begin
            e = sbq.pop_front();
            chk("strobe_type", i, e.ty);
            chk("strobe_cycle", cyc, e.cyc);
            chk("strobe_layer", int'(cur_layer), e.idx);
          end
        end
      end
      busy_tot += int'(busy);
      fc_tot   += int'(fc_en);
      done_tot += int'(done);
      for (int i = 0; i < 4; i++) begin
        resp[i] = 1'b0;
        if (cd[i] > 0) begin
          cd[i]--;
          if (cd[i] == 0) resp[i] = 1'b1;
        end
        if (ev[i] && lat[i] > 0) cd[i] = lat[i];
      end
      fc_prev = fc_en;
    end
    conv_valid_out = resp[0] | spur[0];
    pool_valid_out = resp[1] | spur[1];
    fc_valid       = resp[2] | spur[2];
    act_valid_out  = resp[3] | spur[3];
  endtask

  task automatic cfg_write(input int a, input int t);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 3'(a);
    cfg_wr_type = 2'(t);
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic wait_end(input int bound, output int w);
    w = -1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done || error) begin
        w = cyc;
        break;
      end
    end
    if (w < 0) chk("run_end_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input bit prog);
    int s0, b0, f0, eff;
    ev_t e;
    if (prog) for (int k = 0; k < 8; k++) cfg_write(k, int'(v.ty[k]));
    foreach (lat[i]) lat[i] = v.lat;
    s0 = strobe_tot; b0 = busy_tot; f0 = fc_tot;
    t0  = cyc;
    eff = (v.n > 8) ? 8 : v.n;
    for (int k = 0; k < eff; k++) begin
      e = '{ty: int'(v.ty[k]), cyc: t0 + 1 + k * (v.lat + 2), idx: k};
      sbq.push_back(e);
    end
    cfg_num_layers = 4'(v.n);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_end(200, when);
    chk("done_latency", when - t0, v.exp_done);
    chk("error_low", int'(error), 0);
    chk("busy_at_done", int'(busy), 0);
    tick();
    chk("done_pulse_width", int'(done), 0);
    chk("strobe_count", strobe_tot - s0, v.exp_strobes);
    chk("fc_en_cycles", fc_tot - f0, v.exp_fc);
    chk("busy_cycles", busy_tot - b0, v.exp_done - 1);
    chk("sb_drained", sbq.size(), 0);
    chk("perf_cycles", int'(perf_total_cycles), PERF_ON ? v.exp_done : 0);
  endtask

  initial begin
    vec_t rv;
    int d0;
    ev_t e;
    // done offset = 1 + sum(lat+2) + 1, counted from the cycle start is sampled
    vecs[0] = '{ty: {2'd0,2'd0,2'd0,2'd0,2'd2,2'd3,2'd1,2'd0}, n: 4,  lat: 5,
                exp_done: 30, exp_fc: 6, exp_strobes: 4};
    vecs[1] = '{ty: '0,                                           n: 0,  lat: 5,
                exp_done: 2,  exp_fc: 0, exp_strobes: 0};
    vecs[2] = '{ty: {2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd1,2'd2}, n: 2,  lat: 3,
                exp_done: 12, exp_fc: 4, exp_strobes: 2};
    vecs[3] = '{ty: {2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd3}, n: 1,  lat: 16,
                exp_done: 20, exp_fc: 0, exp_strobes: 1};
    vecs[4] = '{ty: {2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd2}, n: 1,  lat: 1,
                exp_done: 5,  exp_fc: 2, exp_strobes: 1};
    vecs[5] = '{ty: {2'd3,2'd2,2'd1,2'd0,2'd3,2'd2,2'd1,2'd0}, n: 15, lat: 2,
                exp_done: 34, exp_fc: 6, exp_strobes: 8};

    cyc = 0; n_checks = 0; n_pass = 0;
    strobe_tot = 0; busy_tot = 0; fc_tot = 0; done_tot = 0;
    foreach (lat[i]) lat[i] = 0;
    foreach (cd[i]) cd[i] = 0;
    resp = '0; spur = '0; fc_prev = 1'b0;
    rst_n = 1'b0; start = 1'b0; cfg_wr_en = 1'b0;
    cfg_wr_addr = '0; cfg_wr_type = '0; cfg_num_layers = '0;
    conv_valid_out = 1'b0; pool_valid_out = 1'b0; fc_valid = 1'b0; act_valid_out = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_cur_layer", int'(cur_layer), 0);
    chk("rst_strobes", int'({conv_valid_in, pool_valid_in, fc_en, act_valid_in}), 0);
    chk("rst_perf", int'(perf_total_cycles), 0);

    // Reset mid-WAIT of a conv layer whose engine never answers.
    cfg_write(0, 0);
    cfg_write(1, 2);
    foreach (lat[i]) lat[i] = 0;
    t0 = cyc;
    e = '{ty: 0, cyc: t0 + 1, idx: 0};
    sbq.push_back(e);
    cfg_num_layers = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("pre_reset_busy", int'(busy), 1);
    chk("pre_reset_sb", sbq.size(), 0);
    d0 = done_tot;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", int'({busy, done, error, conv_valid_in, fc_en}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_reset_no_done", done_tot - d0, 0);
    // Entry 1 was fc before reset; a cleared table makes both layers conv.
    rv = '{ty: '0, n: 2, lat: 2, exp_done: 10, exp_fc: 0, exp_strobes: 2};
    run_vec(rv, 1'b0);

    for (int v = 0; v < 6; v++) run_vec(vecs[v], 1'b1);

    // Pool engine never answers: watchdog expires after 16 WAIT cycles.
    cfg_write(0, 1);
    foreach (lat[i]) lat[i] = 0;
    d0 = done_tot;
    t0 = cyc;
    e = '{ty: 1, cyc: t0 + 1, idx: 0};
    sbq.push_back(e);
    cfg_num_layers = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_end(60, when);
    chk("timeout_cycle", when - t0, 19);
    chk("timeout_error", int'(error), 1);
    chk("timeout_busy", int'(busy), 0);
    repeat (3) tick();
    chk("error_sticky", int'(error), 1);
    chk("timeout_no_done", done_tot - d0, 0);
    chk("timeout_sb", sbq.size(), 0);
    cfg_num_layers = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("error_cleared_by_start", int'(error), 0);
    wait_end(20, when);
    chk("after_error_done", int'(done), 1);

    // Conv layer with spurious pool/fc completions, plus start and cfg write mid-run.
    cfg_write(0, 0);
    lat[0] = 8; lat[1] = 1; lat[2] = 1; lat[3] = 1;
    t0 = cyc;
    e = '{ty: 0, cyc: t0 + 1, idx: 0};
    sbq.push_back(e);
    cfg_num_layers = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    spur = 4'b0110;
    tick();
    tick();
    start = 1'b1;
    cfg_wr_en = 1'b1; cfg_wr_addr = 3'd0; cfg_wr_type = 2'd3;
    tick();
    start = 1'b0;
    cfg_wr_en = 1'b0;
    wait_end(60, when);
    spur = '0;
    chk("spur_done_latency", when - t0, 12);
    chk("spur_error", int'(error), 0);
    tick();
    // Entry 0 must still be conv.
    rv = '{ty: '0, n: 1, lat: 2, exp_done: 6, exp_fc: 0, exp_strobes: 1};
    run_vec(rv, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
